// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes, FSM state encoding and the counter-width helper
// shared by the sequential ALU and its divider.
// Optional build macro: SEQ_ALU_ITER_MUL_EN adds the MUL_RUN state used by
// the iterative shift-add multiplier.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_EQ  = 3'b101;
  localparam logic [2:0] OP_GT  = 3'b110;
  localparam logic [2:0] OP_LT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
`ifdef SEQ_ALU_ITER_MUL_EN
    MUL_RUN = 2'd2,
`endif
    DIV_RUN = 2'd1
  } state_t;

  // Smallest r with 2**r >= value; sizes the iteration counter so it can hold WIDTH.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result bus of the sequential ALU.
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. The source holds its payload stable while valid && !ready; the input
// side uses in_valid/in_ready, the output side out_valid/out_ready.
interface seq_alu_if #(parameter int WIDTH = 8);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2:0]         opcode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               carry;
  logic               err;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, carry, err
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, carry, err
  );
endinterface

// File: rtl/seq_alu_divider.sv
// seq_alu_divider: restoring divider, one quotient bit per cycle, MSB first.
// 'start' loads the operands; WIDTH iterations follow. 'done' is high in the
// cycle of the final iteration and quotient/remainder then carry that
// iteration's outcome, so the parent registers them on the same edge.
module seq_alu_divider import seq_alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             fits;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] rem_step;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    fits     = rem_sh >= {1'b0, dvs_q};
    rem_sub  = rem_sh[WIDTH-1:0] - dvs_q;
    quo_step = {quo_q[WIDTH-2:0], fits};
    rem_step = fits ? rem_sub : rem_sh[WIDTH-1:0];
  end

  // Load on start, otherwise iterate while the counter is non-zero.
  always_comb begin
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (start) begin
      cnt_d = CW'(WIDTH);
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      quo_d = quo_step;
      rem_d = rem_step;
    end
  end

  assign done      = (cnt_q == CW'(1));
  assign quotient  = quo_step;
  assign remainder = rem_step;

  // Iteration state; reset clears the counter so an aborted run never signals done.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked, registered WIDTH-bit ALU with a multi-cycle divider.
// Optional build macro: SEQ_ALU_ITER_MUL_EN makes MUL an iterative shift-add
// operation timed by the divider's iteration counter; otherwise MUL is a
// single-cycle product.
module seq_alu import seq_alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus,
  output state_t   dbg_state
);
  localparam int W2 = 2 * WIDTH;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [W2-1:0]    result_q, result_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             is_mod_q, is_mod_d;

  logic             accept;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
`ifdef SEQ_ALU_ITER_MUL_EN
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [W2-1:0]    acc_step;
`else
  logic [W2-1:0]    mul_prod;
`endif

  assign bus.in_ready  = (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.err       = err_q;
  assign dbg_state     = state_q;

  assign add_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_diff = bus.a - bus.b;
`ifdef SEQ_ALU_ITER_MUL_EN
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
  assign mul_prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
`endif

  // The iterative multiplier also starts this unit purely for its counter.
  seq_alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (bus.a),
    .divisor   (bus.b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Next-state, output register and flags: consume, accept, complete.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    err_d       = err_q;
    is_mod_d    = is_mod_q;
    div_start   = 1'b0;
`ifdef SEQ_ALU_ITER_MUL_EN
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
`endif
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          carry_d     = 1'b0;
          err_d       = 1'b0;
          case (bus.opcode)
            OP_ADD: begin
              result_d = {{(WIDTH-1){1'b0}}, add_sum};
              carry_d  = add_sum[WIDTH];
            end
            OP_SUB: begin
              result_d = {{WIDTH{1'b0}}, sub_diff};
              carry_d  = bus.a < bus.b;
            end
            OP_MUL: begin
`ifdef SEQ_ALU_ITER_MUL_EN
              out_valid_d = 1'b0;
              div_start   = 1'b1;
              state_d     = MUL_RUN;
              acc_d       = '0;
              mcand_d     = {{WIDTH{1'b0}}, bus.a};
              mplier_d    = bus.b;
`else
              result_d = mul_prod;
`endif
            end
            OP_DIV, OP_MOD: begin
              if (bus.b == '0) begin
                result_d = '0;
                err_d    = 1'b1;
              end else begin
                out_valid_d = 1'b0;
                div_start   = 1'b1;
                state_d     = DIV_RUN;
                is_mod_d    = (bus.opcode == OP_MOD);
              end
            end
            OP_EQ:   result_d = {{(W2-1){1'b0}}, bus.a == bus.b};
            OP_GT:   result_d = {{(W2-1){1'b0}}, bus.a >  bus.b};
            OP_LT:   result_d = {{(W2-1){1'b0}}, bus.a <  bus.b};
            default: ;
          endcase
        end
      end
      DIV_RUN: begin
        if (div_done) begin
          result_d    = {{WIDTH{1'b0}}, is_mod_q ? div_rem : div_quo};
          carry_d     = 1'b0;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
`ifdef SEQ_ALU_ITER_MUL_EN
      MUL_RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (div_done) begin
          result_d    = acc_step;
          carry_d     = 1'b0;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      is_mod_q    <= 1'b0;
`ifdef SEQ_ALU_ITER_MUL_EN
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
      is_mod_q    <= is_mod_d;
`ifdef SEQ_ALU_ITER_MUL_EN
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
`endif
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with hand-computed results for seq_alu
// (WIDTH=8), including backpressure and reset during a divide.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int EW    = 2 * WIDTH + 2;
`ifdef SEQ_ALU_ITER_MUL_EN
  localparam int MUL_LAT  = WIDTH + 1;
  localparam int MUL_BUSY = WIDTH;
`else
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`endif

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_errors = 0;
  logic [EW-1:0] exp_q[$];

  seq_alu_if #(.WIDTH(WIDTH)) bus();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
    end
  endtask

  // ---------------- drivers ----------------
  // Present one operation and hold it until accepted; acc_cyc is the accept edge.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, output int acc_cyc);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.a        = a;
    bus.b        = b;
    acc_cyc      = -1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (acc_cyc < 0) check("accept_timeout", 32'(0), 32'(1));
  endtask

  // Wait for out_valid; busy counts cycles seen with in_ready low before it.
  task automatic wait_out(output int seen_cyc, output int busy);
    seen_cyc = -1;
    busy     = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen_cyc = cyc;
        break;
      end
      if (!bus.in_ready) busy++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2*WIDTH-1:0] exp_res, input logic exp_c,
                        input logic exp_e, input int exp_lat, input int exp_busy);
    int acc, seen, busy;
    logic [EW-1:0] exp_v;
    exp_q.push_back({exp_e, exp_c, exp_res});
    send(op, a, b, acc);
    wait_out(seen, busy);
    exp_v = exp_q.pop_front();
    if (seen < 0) begin
      check({name, "_timeout"}, 32'(0), 32'(1));
    end else begin
      check({name, "_result"}, 32'(bus.result), 32'(exp_v[2*WIDTH-1:0]));
      check({name, "_carry"},  32'(bus.carry),  32'(exp_v[2*WIDTH]));
      check({name, "_err"},    32'(bus.err),    32'(exp_v[2*WIDTH+1]));
      check({name, "_lat"},    32'(seen - acc + 1), 32'(exp_lat));
      check({name, "_busy"},   32'(busy), 32'(exp_busy));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, seen, busy, bad;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.opcode    = OP_ADD;
    bus.out_ready = 1'b1;
    rst           = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_result",    32'(bus.result),    32'(0));
    check("rst_carry",     32'(bus.carry),     32'(0));
    check("rst_err",       32'(bus.err),       32'(0));
    check("rst_in_ready",  32'(bus.in_ready),  32'(0));
    check("rst_state",     32'(dbg_state),     32'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op("add_200_100", OP_ADD, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0, 1, 0);
    run_op("add_ff_01",   OP_ADD, 8'hFF,  8'h01,  16'h0100, 1'b1, 1'b0, 1, 0);
    run_op("add_3_4",     OP_ADD, 8'd3,   8'd4,   16'h0007, 1'b0, 1'b0, 1, 0);
    run_op("sub_7_9",     OP_SUB, 8'd7,   8'd9,   16'h00FE, 1'b1, 1'b0, 1, 0);
    run_op("sub_9_7",     OP_SUB, 8'd9,   8'd7,   16'h0002, 1'b0, 1'b0, 1, 0);
    run_op("mul_ff_ff",   OP_MUL, 8'hFF,  8'hFF,  16'hFE01, 1'b0, 1'b0, MUL_LAT, MUL_BUSY);
    run_op("div_13_4",    OP_DIV, 8'd13,  8'd4,   16'h0003, 1'b0, 1'b0, 9, 8);
    run_op("mod_13_4",    OP_MOD, 8'd13,  8'd4,   16'h0001, 1'b0, 1'b0, 9, 8);
    run_op("div_50_0",    OP_DIV, 8'd50,  8'd0,   16'h0000, 1'b0, 1'b1, 1, 0);
    run_op("mod_7_0",     OP_MOD, 8'd7,   8'd0,   16'h0000, 1'b0, 1'b1, 1, 0);
    run_op("eq_5_5",      OP_EQ,  8'd5,   8'd5,   16'h0001, 1'b0, 1'b0, 1, 0);
    run_op("eq_5_6",      OP_EQ,  8'd5,   8'd6,   16'h0000, 1'b0, 1'b0, 1, 0);
    run_op("gt_3_9",      OP_GT,  8'd3,   8'd9,   16'h0000, 1'b0, 1'b0, 1, 0);
    run_op("gt_9_3",      OP_GT,  8'd9,   8'd3,   16'h0001, 1'b0, 1'b0, 1, 0);
    run_op("lt_3_9",      OP_LT,  8'd3,   8'd9,   16'h0001, 1'b0, 1'b0, 1, 0);
    run_op("div_255_1",   OP_DIV, 8'd255, 8'd1,   16'h00FF, 1'b0, 1'b0, 9, 8);
    run_op("mul_12_12",   OP_MUL, 8'd12,  8'd12,  16'h0090, 1'b0, 1'b0, MUL_LAT, MUL_BUSY);

    // Backpressure: let the last result drain, then stall the consumer.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(OP_ADD, 8'd1, 8'd2, acc);
    wait_out(seen, busy);
    check("bp_lat",    32'(seen - acc + 1), 32'(1));
    check("bp_result", 32'(bus.result), 32'(3));
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!(bus.out_valid && bus.result == 16'd3 && !bus.in_ready)) bad++;
    end
    check("bp_hold", 32'(bad), 32'(0));
    check("bp_in_ready_stalled", 32'(bus.in_ready), 32'(0));
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.opcode    = OP_ADD;
    bus.a         = 8'd4;
    bus.b         = 8'd4;
    #1;
    check("bp_in_ready_on_consume", 32'(bus.in_ready), 32'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid",  32'(bus.out_valid), 32'(1));
    check("bp_next_result", 32'(bus.result),    32'(8));

    // Reset during a divide: nothing may come out of the aborted run.
    send(OP_DIV, 8'd200, 8'd3, acc);
    @(negedge clk);
    check("abort_state_busy", 32'(dbg_state), 32'(DIV_RUN));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready_in_rst", 32'(bus.in_ready), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(bus.out_valid), 32'(0));
    check("abort_result",    32'(bus.result),    32'(0));
    check("abort_state",     32'(dbg_state),     32'(IDLE));
    check("abort_in_ready",  32'(bus.in_ready),  32'(1));
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    check("abort_no_output", 32'(bad), 32'(0));
    run_op("div_200_3", OP_DIV, 8'd200, 8'd3, 16'h0042, 1'b0, 1'b0, 9, 8);
    run_op("mod_200_3", OP_MOD, 8'd200, 8'd3, 16'h0002, 1'b0, 1'b0, 9, 8);

    // ---------------- report ----------------
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked, registered ALU; next generation of the team's 8-bit combinational ALU.
- Same 3-bit opcode set, generalised to WIDTH-bit operands with a 2*WIDTH-bit result.
- Adds carry/borrow and error flags, valid/ready flow control on both sides, and an iterative multi-cycle divider.
- Sits between the instruction decoder and the register-file write-back.

Parameters:
- WIDTH, 8, operand width in bits (>=2); result is 2*WIDTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- opcode  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101 EQ, 110 GT, 111 LT.
- out_valid  out  1  result registered and held.
- out_ready  in  1  consumer takes result.
- result  out  2*WIDTH  operation result.
- carry  out  1  ADD carry-out / SUB borrow; 0 for other ops.
- err  out  1  DIV/MOD with b==0.

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; out_valid=0, result=0, carry=0, err=0. in_ready is 0 during reset.
- Acceptance: a transaction is accepted on a cycle with in_valid && in_ready. Operands and opcode are captured on that edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A new input is accepted in the same cycle the old output is consumed.
- Output hold: out_valid, result, carry and err hold stable while out_valid && !out_ready. out_valid clears on out_ready with no new completion.
- States: IDLE, DIV_RUN.
  - IDLE -> DIV_RUN on accept of DIV/MOD with b!=0.
  - DIV_RUN -> IDLE after WIDTH iterations; result is registered on the final iteration edge.
- Latency (accept edge N):
  - ADD/SUB/MUL/EQ/GT/LT and DIV/MOD-by-zero: out_valid at N+1.
  - DIV/MOD with b!=0: out_valid at N+WIDTH+1.
- Result rules:
  - ADD: result = zero-extended (a+b) on WIDTH+1 bits; carry = bit WIDTH.
  - SUB: result = zero-extended (a-b) mod 2^WIDTH; carry = (a<b).
  - MUL: full 2*WIDTH-bit product.
  - DIV: zero-extended quotient. MOD: zero-extended remainder.
  - EQ/GT/LT: result = 1 or 0.
  - b==0 for DIV/MOD: result = 0, err = 1. err = 0 for every other case.
- Divider: restoring, one quotient bit per cycle, MSB first.
- Reset mid-DIV_RUN aborts the operation. No result is emitted and the partial quotient is discarded.
- in_valid while busy: ignored (in_ready=0). The operands must be held by the source.

Optional Feature:
- Macro: SEQ_ALU_ITER_MUL_EN.
- Defined: MUL uses an iterative shift-add multiplier.
  - IDLE -> MUL_RUN for WIDTH cycles; MUL latency N+WIDTH+1.
  - MUL_RUN shares the divider's iteration counter.
  - Reset in MUL_RUN aborts the operation.
- Undefined: MUL is a single-cycle combinational product with latency N+1; the MUL_RUN state does not exist.

Decomposition:
- Package seq_alu_pkg:
  - Opcode localparams OP_ADD..OP_LT.
  - State encoding (IDLE, DIV_RUN, MUL_RUN).
  - Counter width function clog2(WIDTH+1).
- Sub-module seq_alu_divider, WIDTH-parameterised.
  - Interface: start, dividend, divisor, done pulse, quotient, remainder.
  - seq_alu owns the handshake, the output register and the flags.

Test Plan:
- WIDTH=8, ADD a=200 b=100, out_ready=1 -> out_valid at N+1, result=0x012C, carry=1, err=0.
- SUB a=7 b=9 -> result=0x00FE, carry=1. Then MUL a=255 b=255 -> result=0xFE01.
- DIV a=13 b=4 -> in_ready=0 for 8 cycles, out_valid at N+9, result=0x0003. MOD same operands -> 0x0001.
- DIV a=50 b=0 -> out_valid at N+1, result=0, err=1, no DIV_RUN entry. Then EQ 5,5 -> 1; GT 3,9 -> 0; LT 3,9 -> 1.
- Backpressure: ADD 1+2 completes with out_ready=0 for 5 cycles -> result=3 held, in_ready=0. On out_ready=1 with in_valid (ADD 4+4) -> next result 8 at the following cycle.
- DIV a=200 b=3, rst=1 at cycle N+4 -> out_valid stays 0, state IDLE, in_ready=1 one cycle after rst deasserts. Repeat with SEQ_ALU_ITER_MUL_EN: MUL 12*12 -> 144 at N+9.
